// File: rtl/dac_wavegen.sv
// dac_wavegen: 10-bit sample source for the TLC5615 SPI DAC driver.
// Produces DC, sawtooth, triangle or square codes at a fixed tick rate,
// selected from the slide switches. Samples go out over a valid/ready
// handshake. A tick that finds the previous sample still undelivered
// raises a one-cycle overrun pulse.
module dac_wavegen #(
   parameter int RATE_DIV = 50000,
   parameter int DIV_W    = 16
) (
   input  logic         clk,
   input  logic         Reset,
   input  logic [4:1]   ckey,
   output logic [9:0]   sample_data,
   output logic         sample_valid,
   input  logic         sample_ready,
   output logic         overrun
);

   typedef enum logic [1:0] {
      MODE_DC  = 2'b00,
      MODE_SAW = 2'b01,
      MODE_TRI = 2'b10,
      MODE_SQR = 2'b11
   } mode_t;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);
   localparam logic [9:0]       CODE_MAX = 10'd1023;

   // Switch decode; the switches are sampled by the flops that use them
   mode_t       mode;
   logic [1:0]  ss;
   logic [6:0]  step;

   assign mode = mode_t'(ckey[2:1]);
   assign ss   = ckey[4:3];
   assign step = 7'd1 << {ss, 1'b0};

   // Divider and generator state
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [9:0]       acc;
   logic             dir_up;
   logic [5:0]       sq_phase;
   logic             sq_lvl;
   mode_t            last_mode;

   // Load when a tick finds the output slot free (empty, or emptying now)
   logic slot_free;
   logic load;

   assign tick      = (div_cnt == DIV_LAST);
   assign slot_free = !sample_valid || sample_ready;
   assign load      = tick && slot_free;

   // Free-running sample-rate divider, independent of the handshake
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         // NOTE: clocked state uses non-blocking assignments so every flop
         // sees the pre-edge values of its neighbours regardless of order.
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Next generator state and sample, computed from the state as seen
   // after an optional mode-change clear
   logic [9:0]  base_acc;
   logic        base_up;
   logic [5:0]  base_phase;
   logic        base_lvl;
   logic [9:0]  nxt_acc;
   logic        nxt_up;
   logic [5:0]  nxt_phase;
   logic        nxt_lvl;
   logic [9:0]  nxt_sample;
   logic [10:0] tri_sum;
   logic [6:0]  sq_sum;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      base_acc   = acc;
      base_up    = dir_up;
      base_phase = sq_phase;
      base_lvl   = sq_lvl;
      if (mode != last_mode) begin
         base_acc   = '0;
         base_up    = 1'b1;
         base_phase = '0;
         base_lvl   = 1'b0;
      end

      nxt_acc    = base_acc;
      nxt_up     = base_up;
      nxt_phase  = base_phase;
      nxt_lvl    = base_lvl;
      nxt_sample = base_acc;
      tri_sum    = {1'b0, base_acc} + 11'(step);
      sq_sum     = {1'b0, base_phase} + step;

      unique case (mode)
         MODE_DC: begin
            nxt_sample = 10'(ss) * 10'd341;
         end
         MODE_SAW: begin
            nxt_acc = base_acc + 10'(step);
         end
         MODE_TRI: begin
            if (base_up) begin
               if (tri_sum > 11'(CODE_MAX)) begin
                  nxt_acc = CODE_MAX;
                  nxt_up  = 1'b0;
               end else begin
                  nxt_acc = tri_sum[9:0];
               end
            end else begin
               if (base_acc < 10'(step)) begin
                  nxt_acc = '0;
                  nxt_up  = 1'b1;
               end else begin
                  nxt_acc = base_acc - 10'(step);
               end
            end
         end
         MODE_SQR: begin
            nxt_sample = base_lvl ? CODE_MAX : 10'd0;
            nxt_phase  = sq_sum[5:0];
            nxt_lvl    = base_lvl ^ sq_sum[6];
         end
         default: ;
      endcase
   end

   // Generator state and sample register advance only on a load
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         acc         <= '0;
         dir_up      <= 1'b1;
         sq_phase    <= '0;
         sq_lvl      <= 1'b0;
         last_mode   <= MODE_DC;
         sample_data <= '0;
      end else if (load) begin
         acc         <= nxt_acc;
         dir_up      <= nxt_up;
         sq_phase    <= nxt_phase;
         sq_lvl      <= nxt_lvl;
         last_mode   <= mode;
         sample_data <= nxt_sample;
      end
   end

   // Handshake: a load sets valid, a transfer without a load clears it,
   // and a tick on an occupied slot flags an overrun for one cycle
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         sample_valid <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         overrun <= tick && !slot_free;
         if (load) begin
            sample_valid <= 1'b1;
         end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dac_wavegen.sv
// tb_dac_wavegen: randomized and directed checks of dac_wavegen against a
// behavioural model that follows the waveform rules with plain integers.
module tb_dac_wavegen;

   localparam int RD = 8;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic [4:1] ckey = 4'b1100;
   logic       sample_ready = 1'b1;
   logic [9:0] sample_data;
   logic       sample_valid;
   logic       overrun;

   dac_wavegen #(.RATE_DIV(RD), .DIV_W(16)) dut (
      .clk          (clk),
      .Reset        (Reset),
      .ckey         (ckey),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Behavioural model state
   int m_cnt;
   bit m_valid;
   int m_data;
   bit m_ovr;
   int m_acc;
   bit m_up;
   int m_phase;
   bit m_lvl;
   int m_last;

   task automatic model_reset();
      m_cnt = 0; m_valid = 0; m_data = 0; m_ovr = 0;
      m_acc = 0; m_up = 1; m_phase = 0; m_lvl = 0; m_last = 0;
   endtask

   task automatic model_edge();
      int mode;
      int ss;
      int step;
      bit tk;
      mode = int'(ckey[2:1]);
      ss   = int'(ckey[4:3]);
      step = 1 << (2 * ss);
      tk   = (m_cnt == RD - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
      if (tk && (!m_valid || sample_ready)) begin
         if (mode != m_last) begin
            m_acc = 0; m_up = 1; m_phase = 0; m_lvl = 0;
         end
         m_last = mode;
         case (mode)
            0: m_data = ss * 341;
            1: begin
               m_data = m_acc;
               m_acc  = (m_acc + step) % 1024;
            end
            2: begin
               m_data = m_acc;
               if (m_up) begin
                  if (m_acc + step > 1023) begin m_acc = 1023; m_up = 0; end
                  else m_acc = m_acc + step;
               end else begin
                  if (m_acc < step) begin m_acc = 0; m_up = 1; end
                  else m_acc = m_acc - step;
               end
            end
            default: begin
               m_data  = m_lvl ? 1023 : 0;
               m_phase = m_phase + step;
               if (m_phase >= 64) begin m_phase = m_phase - 64; m_lvl = !m_lvl; end
            end
         endcase
         m_valid = 1;
         m_ovr   = 0;
      end else if (tk) begin
         m_ovr = 1;
      end else begin
         m_ovr = 0;
         if (m_valid && sample_ready) m_valid = 0;
      end
   endtask

   // Model advances on the same events as the design
   initial begin
      model_reset();
      forever begin
         @(posedge clk or posedge Reset);
         if (Reset) model_reset();
         else model_edge();
      end
   end

   // Every cycle, compare outputs to the model away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         check("valid", 16'(sample_valid), 16'(m_valid));
         check("data", 16'(sample_data), 16'(m_data));
         check("overrun", 16'(overrun), 16'(m_ovr));
      end
   end

   // Stop on the negedge just before a tick edge (bounded)
   task automatic align_pre_tick();
      bit found;
      found = 0;
      for (int i = 0; i < RD + 2 && !found; i++) begin
         @(negedge clk);
         if (m_cnt == RD - 1) found = 1;
      end
      check("align", 16'(found), 16'd1);
   endtask

   initial begin
      int exp_first;
      int ovr_cnt;

      // Reset values while Reset is high
      #3;
      check("rst_valid", 16'(sample_valid), 16'd0);
      check("rst_data", 16'(sample_data), 16'd0);
      check("rst_overrun", 16'(overrun), 16'd0);
      repeat (2) @(negedge clk);
      Reset = 1'b0;

      // DC level 1023: valid only after the RATE_DIV-th edge
      repeat (RD - 1) @(negedge clk);
      check("first_tick_early", 16'(sample_valid), 16'd0);
      @(negedge clk);
      check("first_tick_valid", 16'(sample_valid), 16'd1);
      check("first_tick_data", 16'(sample_data), 16'd1023);
      repeat (4 * RD) @(negedge clk);

      // Sawtooth step 64 through a wrap
      ckey = 4'b1101;
      repeat (20 * RD) @(negedge clk);

      // Triangle step 64 through both clamps
      ckey = 4'b1110;
      repeat (40 * RD) @(negedge clk);

      // Square step 16, then step 64
      ckey = 4'b1011;
      repeat (12 * RD) @(negedge clk);
      ckey = 4'b1111;
      repeat (6 * RD) @(negedge clk);

      // Backpressure across three ticks on a sawtooth
      ckey = 4'b1101;
      repeat (4 * RD) @(negedge clk);
      align_pre_tick();
      sample_ready = 1'b0;
      ovr_cnt = 0;
      @(negedge clk);
      exp_first = m_data;
      check("bp_load", 16'(sample_data), 16'(exp_first));
      for (int i = 1; i < 3 * RD; i++) begin
         @(negedge clk);
         if (overrun) ovr_cnt++;
      end
      check("bp_frozen", 16'(sample_data), 16'(exp_first));
      check("bp_valid_held", 16'(sample_valid), 16'd1);
      check("bp_overruns", 16'(ovr_cnt), 16'd2);
      sample_ready = 1'b1;
      @(negedge clk);
      check("bp_resume", 16'(sample_data), 16'((exp_first + 64) % 1024));
      repeat (3 * RD) @(negedge clk);

      // Mode switch mid-ramp: first triangle sample is 0
      repeat (RD / 2) @(negedge clk);
      ckey = 4'b1110;
      align_pre_tick();
      @(negedge clk);
      check("tri_after_switch", 16'(sample_data), 16'd0);
      repeat (2 * RD) @(negedge clk);

      // Randomized switches and ready
      for (int i = 0; i < 60 * RD; i++) begin
         @(negedge clk);
         sample_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) ckey = 4'($urandom);
      end
      sample_ready = 1'b1;
      repeat (2 * RD) @(negedge clk);

      // Asynchronous reset between edges
      @(negedge clk);
      #2;
      Reset = 1'b1;
      #1;
      check("arst_valid", 16'(sample_valid), 16'd0);
      check("arst_data", 16'(sample_data), 16'd0);
      check("arst_overrun", 16'(overrun), 16'd0);
      @(negedge clk);
      Reset = 1'b0;
      ckey = 4'b0100;
      repeat (RD) @(negedge clk);
      check("post_rst_data", 16'(sample_data), 16'd341);
      repeat (2 * RD) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dac_wavegen.md
# dac_wavegen

Sample source placed directly upstream of the TLC5615 SPI DAC driver on the EPM240/EPM570 board. It produces a 10-bit DAC code stream (DC level, sawtooth, triangle or square) at a fixed sample rate, selected live by the four slide switches. Samples are delivered over a valid/ready handshake, so the SPI stage pulls a code once per frame. Samples that cannot be delivered in time are flagged as overruns.

## Interface
- RATE_DIV, 50000: clk cycles per sample tick (1 kHz at 50 MHz); legal range 2..65535
- DIV_W, 16: width of the rate divider counter; must hold RATE_DIV-1
- clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high reset
- ckey  in  [4:1]  slide switches, sampled synchronously: ckey[2:1] = mode, ckey[4:3] = step select ss
- sample_data  out  10  DAC code, D9..D0
- sample_valid  out  1  sample_data holds an undelivered sample
- sample_ready  in  1  consumer accepts; transfer occurs on a clk edge with valid & ready both high
- overrun  out  1  one-cycle pulse: a tick found the previous sample still undelivered

## Operation
- Modes (ckey[2:1]):
  - 00 = DC
  - 01 = sawtooth
  - 10 = triangle
  - 11 = square
- step = 1 << (2*ss), giving 1, 4, 16 or 64.
- Internal state:
  - acc, 10 bit
  - dir, 1 = up
  - sq_phase, 6 bit
  - sq_lvl, 1 bit
  - last_mode, 2 bit
- Divider: div_cnt counts 0..RATE_DIV-1 and wraps. tick = (div_cnt == RATE_DIV-1). It runs freely and is never stalled by the handshake.
- On a tick with the slot free (valid low, or valid & ready in the same cycle), a new sample is loaded and valid is set:
  - Mode change: if mode != last_mode, clear acc, sq_phase and sq_lvl, set dir up, then load per the new mode. last_mode <= mode.
  - DC: sample = ss * 341, giving 0, 341, 682, 1023. acc is unused.
  - Sawtooth: sample = acc; acc <= acc + step, modulo 1024 (natural wrap).
  - Triangle: sample = acc.
    - Going up: if acc + step > 1023, acc <= 1023 and dir <= down; else acc += step.
    - Going down: if acc < step, acc <= 0 and dir <= up; else acc -= step.
    - Sum is computed 11 bit wide, with no wrap.
  - Square: sample = sq_lvl ? 1023 : 0. {carry, sq_phase} <= sq_phase + step; sq_lvl toggles when carry = 1. Half-period is 64, 16, 4 or 1 ticks.
- On a tick with the slot occupied (valid high, ready low):
  - sample_data is held.
  - No generator state advances and last_mode is not updated.
  - overrun pulses high for exactly that cycle.
- Transfer without a tick: valid goes low on the next edge; sample_data keeps its last value.
- Tick and transfer in the same cycle: the new sample loads, valid stays high, no overrun.
- ckey changes between ticks have no effect until the next tick.

## Timing
- Reset values while Reset is high:
  - sample_data = 0, sample_valid = 0, overrun = 0
  - div_cnt = 0, acc = 0, dir = up
  - sq_phase = 0, sq_lvl = 0, last_mode = 00
- Reset mid-transfer discards the pending sample.
- The first tick is on the RATE_DIV-th rising edge after Reset deasserts. sample_valid and the first sample are visible after that edge. Latency from tick to valid is 1 clk.
- Sample period is exactly RATE_DIV clk cycles, regardless of ready.
- sample_data is stable whenever sample_valid = 1 and no transfer has occurred. valid never drops without a transfer.
- All outputs are registered; no combinational path from sample_ready to any output.

## Test plan
- Reset, then DC: RATE_DIV = 8, ckey = 4'b1100 (ss = 3, mode 00), ready held 1. valid rises after edge 8; data = 1023 on every tick; overrun never asserts.
- Sawtooth wrap: ckey = 4'b1101 (step 64), ready = 1. Data sequence is 0, 64, ..., 960, then 0 (wrap after 16 samples).
- Triangle: ckey = 4'b1110 (step 64), ready = 1. Data runs 0 … 960, 1023, 959, … 63, 0, 64 …, showing clamping at 1023 and at 0 and the direction reversals.
- Square: ckey = 4'b1011 (step 16). Data is 0 for 4 samples, then 1023 for 4 samples, repeating. With ss = 3, data alternates 0/1023 every sample.
- Backpressure: ready = 0 across 3 ticks.
  - valid stays high and data is frozen at the first sample.
  - overrun pulses on the 2nd and 3rd tick.
  - On the next tick after ready rises, the sawtooth continues from the held value + step, with no skipped codes.
- Mode switch and async reset:
  - Switch from sawtooth to triangle mid-ramp: the first triangle sample is 0.
  - Assert Reset between clk edges: all outputs go to their reset values immediately, with no edge needed.
